// File: rtl/rng_sampler_pkg.sv
// Shared constants for the entropy sampler: word geometry and von Neumann pair decode.
package rng_sampler_pkg;

  localparam int unsigned RNG_WORD_W = 32;
  localparam int unsigned RNG_BCNT_W = 6;

  // Pair is {first_sample, second_sample}.
  typedef enum logic [1:0] {
    VnPair00 = 2'b00,
    VnPair01 = 2'b01,
    VnPair10 = 2'b10,
    VnPair11 = 2'b11
  } vn_pair_e;

  function automatic logic vn_emits(input logic [1:0] pair);
    return (pair == VnPair01) || (pair == VnPair10);
  endfunction

endpackage

// File: rtl/rng_ehr_fifo.sv
// First-word-fall-through word FIFO; full-with-pop accepts the push, full-without-pop drops it.
module rng_ehr_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter int unsigned LvlW  = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [Width-1:0] rdata,
  output logic [LvlW-1:0]  level,
  output logic             drop
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [LvlW-1:0]  wptr_q, rptr_q;
  logic             empty, full, do_pop, do_push;

  // Pointers carry an extra wrap bit so their difference is the fill level.
  assign level   = wptr_q - rptr_q;
  assign empty   = (level == '0);
  assign full    = (level == LvlW'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign valid   = !empty;
  assign rdata   = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AddrW-1:0]] <= wdata;
        wptr_q <= wptr_q + LvlW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + LvlW'(1);
    end
  end

endmodule

// File: rtl/rng_src_sampler.sv
// Noise-source sampler: synchroniser, period strobe, von Neumann corrector, 32-bit packer and
// word FIFO toward the engine.
module rng_src_sampler
  import rng_sampler_pkg::*;
#(
  parameter int unsigned SMPL_CNT_W = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  rng_clk,
  input  logic                  rst_n,
  input  logic                  rnd_src,
  input  logic                  smpl_en,
  input  logic [SMPL_CNT_W-1:0] sample_cnt,
  input  logic                  vnc_bypass,
  input  logic                  ovf_clr,
  input  logic                  ehr_ready,
  output logic                  ehr_valid,
  output logic [31:0]           ehr_data,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  ovf_err
);

  logic                  src_meta, src_s;
  logic [SMPL_CNT_W-1:0] period, pcnt_q, pcnt_d;
  logic                  stb;
  logic                  half_q, half_d, first_q, first_d, bypass_q;
  logic [RNG_WORD_W-1:0] word_q, word_d;
  logic [RNG_BCNT_W-1:0] bcnt_q, bcnt_d;
  logic                  emit, emit_bit, push, drop;
  logic                  ovf_d;

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      src_meta <= 1'b0;
      src_s    <= 1'b0;
    end else begin
      src_meta <= rnd_src;
      src_s    <= src_meta;
    end
  end

  // sample_cnt is live; >= lets a shrinking period strobe and wrap immediately.
  assign period = (sample_cnt == '0) ? SMPL_CNT_W'(1) : sample_cnt;
  assign stb    = smpl_en && (pcnt_q >= (period - SMPL_CNT_W'(1)));

  always_comb begin
    pcnt_d = pcnt_q + SMPL_CNT_W'(1);
    if (!smpl_en || stb) pcnt_d = '0;
  end

  always_comb begin
    half_d   = half_q;
    first_d  = first_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;
    emit     = 1'b0;
    emit_bit = src_s;
    push     = 1'b0;
    if (!smpl_en) begin
      half_d = 1'b0;
      word_d = '0;
      bcnt_d = '0;
    end else begin
      if (vnc_bypass) begin
        half_d = 1'b0;
        emit   = stb;
      end else if (!bypass_q) begin
        if (stb) begin
          if (!half_q) begin
            first_d = src_s;
            half_d  = 1'b1;
          end else begin
            half_d   = 1'b0;
            emit     = vn_emits({first_q, src_s});
            emit_bit = first_q;
          end
        end
      end else begin
        // Just switched into corrected mode: restart pairing.
        half_d = 1'b0;
      end
      if (emit) begin
        word_d = {word_q[RNG_WORD_W-2:0], emit_bit};
        if (bcnt_q == RNG_BCNT_W'(RNG_WORD_W - 1)) begin
          push   = 1'b1;
          bcnt_d = '0;
        end else begin
          bcnt_d = bcnt_q + RNG_BCNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    ovf_d = ovf_err;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      half_q   <= 1'b0;
      first_q  <= 1'b0;
      bypass_q <= 1'b0;
      word_q   <= '0;
      bcnt_q   <= '0;
      ovf_err  <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      half_q   <= half_d;
      first_q  <= first_d;
      bypass_q <= vnc_bypass;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      ovf_err  <= ovf_d;
    end
  end

  rng_ehr_fifo #(
    .Width (RNG_WORD_W),
    .Depth (FIFO_DEPTH),
    .LvlW  (LVL_W)
  ) u_fifo (
    .clk   (rng_clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (word_d),
    .pop   (ehr_ready),
    .valid (ehr_valid),
    .rdata (ehr_data),
    .level (fifo_level),
    .drop  (drop)
  );

endmodule

// File: tb/tb_rng_src_sampler.sv
// Directed bench for rng_src_sampler: bypass/VN packing, period timing, FIFO overflow and resets.
module tb_rng_src_sampler;

  logic        rng_clk = 1'b0;
  logic        rst_n;
  logic        rnd_src;
  logic        smpl_en;
  logic [15:0] sample_cnt;
  logic        vnc_bypass;
  logic        ovf_clr;
  logic        ehr_ready;
  logic        ehr_valid;
  logic [31:0] ehr_data;
  logic [2:0]  fifo_level;
  logic        ovf_err;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n;
  logic [31:0] pats [8];
  logic [9:0]  vn_seq = 10'b0110001110;

  always #5 rng_clk = ~rng_clk;

  rng_src_sampler #(
    .SMPL_CNT_W (16),
    .FIFO_DEPTH (4),
    .LVL_W      (3)
  ) dut (
    .rng_clk    (rng_clk),
    .rst_n      (rst_n),
    .rnd_src    (rnd_src),
    .smpl_en    (smpl_en),
    .sample_cnt (sample_cnt),
    .vnc_bypass (vnc_bypass),
    .ovf_clr    (ovf_clr),
    .ehr_ready  (ehr_ready),
    .ehr_valid  (ehr_valid),
    .ehr_data   (ehr_data),
    .fifo_level (fifo_level),
    .ovf_err    (ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bit that sample s (1-based enabled cycle, P=1) should see; word w covers samples 32w+1..32w+32.
  function automatic logic fbit(input int s);
    int          w;
    int          idx;
    logic [31:0] t;
    w = (s - 1) / 32;
    if (w > 7) return 1'b0;
    idx = 31 - ((s - 1) % 32);
    t = pats[w];
    return t[idx];
  endfunction

  function automatic logic vn_bit(input int m);
    logic [9:0] t;
    t = vn_seq;
    return t[9 - ((m - 1) % 10)];
  endfunction

  // Bypass, P=1: drive rnd_src two cycles ahead so the synchronised bit lands on its sample.
  task automatic gen_words(input int nw, input int pop_cycle);
    @(negedge rng_clk) rnd_src = fbit(1);
    @(negedge rng_clk) rnd_src = fbit(2);
    @(negedge rng_clk);
    smpl_en   = 1'b1;
    rnd_src   = fbit(3);
    ehr_ready = (pop_cycle == 1);
    for (int c = 2; c <= 32 * nw + 1; c++) begin
      @(negedge rng_clk);
      rnd_src   = fbit(c + 2);
      ehr_ready = (c == pop_cycle);
    end
    smpl_en   = 1'b0;
    ehr_ready = 1'b0;
  endtask

  // Enable sampling and count edges until the first word is visible (bounded).
  task automatic measure(input int max, output int cnt);
    cnt     = 0;
    smpl_en = 1'b1;
    while (cnt < max) begin
      @(negedge rng_clk);
      cnt++;
      if (fifo_level != 3'd0) break;
    end
    smpl_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check(tag, ehr_data, exp);
    ehr_ready = 1'b1;
    @(negedge rng_clk);
    ehr_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    rnd_src    = 1'b1;
    smpl_en    = 1'b0;
    sample_cnt = 16'd1;
    vnc_bypass = 1'b1;
    ovf_clr    = 1'b0;
    ehr_ready  = 1'b0;
    #12;
    check("rst_valid", ehr_valid, 0);
    check("rst_data", ehr_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", ovf_err, 0);
    @(negedge rng_clk) rst_n = 1'b1;
    repeat (3) @(negedge rng_clk);

    // Bypass, all ones, P=1
    measure(100, n);
    check("p1_latency", n, 32);
    check("p1_valid", ehr_valid, 1);
    check("p1_data", ehr_data, 32'hFFFF_FFFF);
    check("p1_level", fifo_level, 1);
    pop_check("p1_pop", 32'hFFFF_FFFF);
    check("p1_drained", fifo_level, 0);
    check("p1_valid_low", ehr_valid, 0);

    // Period 0 behaves as 1
    sample_cnt = 16'd0;
    measure(100, n);
    check("p0_latency", n, 32);
    pop_check("p0_data", 32'hFFFF_FFFF);

    // Period 5, all zeros
    sample_cnt = 16'd5;
    rnd_src    = 1'b0;
    repeat (3) @(negedge rng_clk);
    measure(400, n);
    check("p5_latency", n, 160);
    check("p5_valid", ehr_valid, 1);
    pop_check("p5_data", 32'h0);

    // Von Neumann, P=4, pairs 01,10,00,11,10 -> bits 0,1,1 repeating
    sample_cnt = 16'd4;
    vnc_bypass = 1'b0;
    repeat (2) @(negedge rng_clk);
    smpl_en = 1'b1;
    rnd_src = vn_bit(1);
    n = 0;
    while (n < 600) begin
      @(negedge rng_clk);
      n++;
      if (fifo_level != 3'd0) break;
      rnd_src = vn_bit((n + 4) / 4);
    end
    smpl_en = 1'b0;
    check("vn_latency", n, 416);
    check("vn_level", fifo_level, 1);
    pop_check("vn_data", 32'h6DB6_DB6D);
    vnc_bypass = 1'b1;
    sample_cnt = 16'd1;

    // Overflow: 5 words into a 4-deep FIFO with no reads
    pats[0] = 32'hA5A5_0001;
    pats[1] = 32'h1234_5678;
    pats[2] = 32'hDEAD_BEEF;
    pats[3] = 32'h0F0F_F0F0;
    pats[4] = 32'hCAFE_0005;
    gen_words(5, 0);
    check("ovf_level", fifo_level, 4);
    check("ovf_set", ovf_err, 1);
    pop_check("ovf_w0", 32'hA5A5_0001);
    pop_check("ovf_w1", 32'h1234_5678);
    pop_check("ovf_w2", 32'hDEAD_BEEF);
    pop_check("ovf_w3", 32'h0F0F_F0F0);
    check("ovf_drained", fifo_level, 0);
    check("ovf_no5th", ehr_valid, 0);
    check("ovf_sticky", ovf_err, 1);
    ovf_clr = 1'b1;
    @(negedge rng_clk) ovf_clr = 1'b0;
    check("ovf_clr", ovf_err, 0);

    // Full FIFO with pop in the push cycle
    pats[0] = 32'h1111_0000;
    pats[1] = 32'h2222_0001;
    pats[2] = 32'h3333_0002;
    pats[3] = 32'h4444_0003;
    gen_words(4, 0);
    check("fp_full", fifo_level, 4);
    pats[0] = 32'h5555_0004;
    gen_words(1, 32);
    check("fp_level", fifo_level, 4);
    check("fp_no_ovf", ovf_err, 0);
    pop_check("fp_w1", 32'h2222_0001);
    pop_check("fp_w2", 32'h3333_0002);
    pop_check("fp_w3", 32'h4444_0003);
    pop_check("fp_w4", 32'h5555_0004);
    check("fp_drained", fifo_level, 0);

    // Disable after 10 bits discards the partial word
    rnd_src = 1'b1;
    repeat (3) @(negedge rng_clk);
    smpl_en = 1'b1;
    repeat (10) @(negedge rng_clk);
    smpl_en = 1'b0;
    check("dis_no_push", fifo_level, 0);
    pats[0] = 32'h0;
    gen_words(1, 0);
    check("dis_level", fifo_level, 1);
    check("dis_data", ehr_data, 32'h0);

    // Asynchronous reset mid-word with a word held
    rnd_src = 1'b1;
    repeat (3) @(negedge rng_clk);
    smpl_en = 1'b1;
    repeat (12) @(negedge rng_clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ehr_valid, 0);
    check("arst_level", fifo_level, 0);
    check("arst_data", ehr_data, 0);
    check("arst_ovf", ovf_err, 0);
    smpl_en = 1'b0;
    @(negedge rng_clk) rst_n = 1'b1;
    pats[0] = 32'h8765_4321;
    gen_words(1, 0);
    check("post_rst_level", fifo_level, 1);
    check("post_rst_data", ehr_data, 32'h8765_4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
